// File: rtl/ccd_pkg.sv
// ccd_pkg: shared types and constants for the TCD1290D line scheduler and driver.
package ccd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT_TRIG,
        START,
        RUN,
        HOLD
    } state_e;

    localparam logic [9:0]  MIN_F1_CNT_DEF = 10'd4;
    localparam logic [23:0] MIN_PERIOD_DEF = 24'd2000;

    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_TRIG = 1'b1;

    localparam int LINE_WIDTH = 2100;

endpackage

// File: rtl/ccd_line_scheduler_if.sv
// ccd_line_scheduler_if: config, trigger and driver-feedback bundle of the scheduler.
interface ccd_line_scheduler_if #(
    parameter int PERIOD_W = 24,
    parameter int LINES_W  = 16
);

    logic                enable;
    logic                cfg_mode;
    logic [9:0]          cfg_f1_cnt;
    logic [PERIOD_W-1:0] cfg_period;
    logic [LINES_W-1:0]  cfg_lines;
    logic                ext_trig;
    logic                line_done;
    logic                clr_overrun;

    logic                line_start;
    logic [9:0]          f1_cnt;
    logic [LINES_W-1:0]  line_idx;
    logic                frame_start;
    logic                frame_end;
    logic                busy;
    logic                trig_overrun;

    modport master (
        output enable, cfg_mode, cfg_f1_cnt, cfg_period, cfg_lines,
        output ext_trig, line_done, clr_overrun,
        input  line_start, f1_cnt, line_idx, frame_start, frame_end,
        input  busy, trig_overrun
    );

    modport slave (
        input  enable, cfg_mode, cfg_f1_cnt, cfg_period, cfg_lines,
        input  ext_trig, line_done, clr_overrun,
        output line_start, f1_cnt, line_idx, frame_start, frame_end,
        output busy, trig_overrun
    );

endinterface

// File: rtl/ccd_trig_edge.sv
// ccd_trig_edge: rising-edge detector for ext_trig, 1-cycle pulse out.
// TRIG_SYNC_EN inserts a 2-flop synchronizer ahead of the detector.
module ccd_trig_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    output logic pulse_o
);

    logic lvl;
    logic prev_q;

`ifdef TRIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], trig_i};
        end
    end

    assign lvl = sync_q[1];
`else
    assign lvl = trig_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign pulse_o = lvl & ~prev_q;

endmodule

// File: rtl/ccd_line_scheduler.sv
// ccd_line_scheduler: paces TCD1290D line readouts, latches f1_cnt per line.
// Build option: TRIG_SYNC_EN (synchronized ext_trig, 3-cycle trigger latency).
module ccd_line_scheduler
    import ccd_pkg::*;
#(
    parameter int                  PERIOD_W   = 24,
    parameter int                  LINES_W    = 16,
    parameter logic [9:0]          MIN_F1_CNT = MIN_F1_CNT_DEF,
    parameter logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(MIN_PERIOD_DEF)
) (
    input  logic                sys_clk,
    input  logic                rst,
    ccd_line_scheduler_if.slave bus
);

    state_e              state_q, state_d;
    logic [9:0]          f1_q, f1_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LINES_W-1:0]  lines_q, lines_d;
    logic [LINES_W-1:0]  idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;
    logic                trig_pulse;
    logic                last_line;
    logic                ls, fs, fe;

    ccd_trig_edge u_trig (
        .clk_i   (sys_clk),
        .rst_i   (rst),
        .trig_i  (bus.ext_trig),
        .pulse_o (trig_pulse)
    );

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + PERIOD_W'(1);
    assign last_line = (idx_q == lines_q - LINES_W'(1));

    always_comb begin
        state_d  = state_q;
        f1_d     = f1_q;
        period_d = period_q;
        lines_d  = lines_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        ls       = 1'b0;
        fs       = 1'b0;
        fe       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) state_d = LATCH;
            end
            LATCH: begin
                f1_d     = (bus.cfg_f1_cnt < MIN_F1_CNT) ? MIN_F1_CNT
                                                         : bus.cfg_f1_cnt;
                period_d = (bus.cfg_period < MIN_PERIOD) ? MIN_PERIOD
                                                         : bus.cfg_period;
                lines_d  = (bus.cfg_lines == '0) ? LINES_W'(1) : bus.cfg_lines;
                state_d  = (bus.cfg_mode == MODE_TRIG) ? WAIT_TRIG : START;
            end
            WAIT_TRIG: begin
                if (!bus.enable)     state_d = IDLE;
                else if (trig_pulse) state_d = START;
            end
            START: begin
                ls      = 1'b1;
                fs      = (idx_q == '0);
                busy_d  = 1'b1;
                cnt_d   = PERIOD_W'(1);
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (bus.line_done) begin
                    busy_d  = 1'b0;
                    fe      = last_line;
                    idx_d   = last_line ? '0 : idx_q + LINES_W'(1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // compare the post-increment count so start-to-start is period+1
                cnt_d = cnt_inc;
                if (cnt_inc >= period_q) state_d = bus.enable ? LATCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (bus.clr_overrun) ovr_d = 1'b0;
        if (trig_pulse && bus.cfg_mode == MODE_TRIG && state_q != WAIT_TRIG)
            ovr_d = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            f1_q     <= MIN_F1_CNT;
            period_q <= MIN_PERIOD;
            lines_q  <= LINES_W'(1);
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            f1_q     <= f1_d;
            period_q <= period_d;
            lines_q  <= lines_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.line_start   = ls;
    assign bus.frame_start  = fs;
    assign bus.frame_end    = fe;
    assign bus.f1_cnt       = f1_q;
    assign bus.line_idx     = idx_q;
    assign bus.busy         = busy_q;
    assign bus.trig_overrun = ovr_q;

endmodule

// File: tb/tb_ccd_line_scheduler.sv
// tb_ccd_line_scheduler: scoreboard bench for ccd_line_scheduler.
// Line starts and frame ends are queued with hand-computed cycles and popped by a monitor.
module tb_ccd_line_scheduler;

    typedef struct {
        int cyc;
        int f1;
        int idx;
        int fs;
    } exp_t;

`ifdef TRIG_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    int   done_dly = 0;
    bit   drv_abort;
    exp_t ls_q[$];
    int   fe_q[$];
    exp_t ex;
    int   fe_exp;

    ccd_line_scheduler_if #(.PERIOD_W(24), .LINES_W(16)) bus ();

    ccd_line_scheduler #(.PERIOD_W(24), .LINES_W(16)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push_ls(input int c, input int f1, input int idx,
                           input int fs);
        exp_t e;
        e.cyc = c;
        e.f1  = f1;
        e.idx = idx;
        e.fs  = fs;
        ls_q.push_back(e);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.enable = 1'b0;
        goto(cyc + 2);
        rst = 1'b0;
    endtask

    // line_done driver: pulse done_dly cycles after each line_start
    initial begin
        bus.line_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.line_start && done_dly > 0) begin
                drv_abort = 1'b0;
                for (int n = 0; n < done_dly; n++) begin
                    @(posedge sys_clk);
                    if (rst) begin
                        drv_abort = 1'b1;
                        break;
                    end
                end
                if (!drv_abort) begin
                    #1 bus.line_done = 1'b1;
                    @(posedge sys_clk);
                    #1 bus.line_done = 1'b0;
                end
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge sys_clk);
            if (bus.line_start) begin
                checks++;
                if (ls_q.size() == 0) begin
                    errors++;
                    $display("FAIL line_start: unexpected at cycle %0d", cyc);
                end else begin
                    ex = ls_q.pop_front();
                    if (cyc != ex.cyc || int'(bus.f1_cnt) != ex.f1 ||
                        int'(bus.line_idx) != ex.idx ||
                        int'(bus.frame_start) != ex.fs) begin
                        errors++;
                        $display("FAIL line_start: got cyc=%0d f1=%0d idx=%0d fs=%0d, expected cyc=%0d f1=%0d idx=%0d fs=%0d",
                                 cyc, bus.f1_cnt, bus.line_idx, bus.frame_start,
                                 ex.cyc, ex.f1, ex.idx, ex.fs);
                    end
                end
            end else if (bus.frame_start) begin
                checks++;
                errors++;
                $display("FAIL frame_start: without line_start at cycle %0d", cyc);
            end
            if (bus.frame_end) begin
                checks++;
                if (fe_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_end: unexpected at cycle %0d", cyc);
                end else begin
                    fe_exp = fe_q.pop_front();
                    if (cyc != fe_exp) begin
                        errors++;
                        $display("FAIL frame_end: got cycle %0d, expected %0d",
                                 cyc, fe_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, s1, s2, s3, t, t2;
        bus.enable      = 1'b0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_f1_cnt  = 10'd25;
        bus.cfg_period  = 24'd5000;
        bus.cfg_lines   = 16'd3;
        bus.ext_trig    = 1'b0;
        bus.clr_overrun = 1'b0;
        goto(2);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_line_start", 32'(bus.line_start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_line_idx", 32'(bus.line_idx), 0);
        chk("rst_f1_cnt", 32'(bus.f1_cnt), 4);
        chk("rst_overrun", 32'(bus.trig_overrun), 0);

        // free-run, 3 lines per frame
        done_dly = 3000;
        e = cyc;
        bus.enable = 1'b1;
        s1 = e + 2;
        for (int k = 0; k < 4; k++)
            push_ls(s1 + k * 5001, 25, k % 3, (k % 3 == 0) ? 1 : 0);
        fe_q.push_back(s1 + 2 * 5001 + 3000);
        goto(s1 + 5);
        @(negedge sys_clk);
        chk("fr_busy_run", 32'(bus.busy), 1);
        chk("fr_f1_cnt", 32'(bus.f1_cnt), 25);
        goto(s1 + 3005);
        @(negedge sys_clk);
        chk("fr_busy_hold", 32'(bus.busy), 0);
        chk("fr_idx_after_done", 32'(bus.line_idx), 1);

        // reset during RUN
        goto(s1 + 3 * 5001 + 10);
        rst = 1'b1;
        bus.enable = 1'b0;
        goto(cyc + 1);
        @(negedge sys_clk);
        chk("runrst_busy", 32'(bus.busy), 0);
        chk("runrst_idx", 32'(bus.line_idx), 0);
        chk("runrst_f1", 32'(bus.f1_cnt), 4);
        chk("runrst_line_start", 32'(bus.line_start), 0);
        chk("runrst_frame_end", 32'(bus.frame_end), 0);
        rst = 1'b0;
        goto(cyc + 30);

        // clamps
        bus.cfg_f1_cnt = 10'd1;
        bus.cfg_period = 24'd10;
        bus.cfg_lines  = 16'd0;
        done_dly = 100;
        do_reset();
        e = cyc;
        bus.enable = 1'b1;
        s1 = e + 2;
        for (int k = 0; k < 3; k++) begin
            push_ls(s1 + k * 2001, 4, 0, 1);
            fe_q.push_back(s1 + k * 2001 + 100);
        end
        goto(s1 + 2 * 2001 + 150);
        bus.enable = 1'b0;
        goto(s1 + 2 * 2001 + 2100);
        @(negedge sys_clk);
        chk("clamp_busy_idle", 32'(bus.busy), 0);
        chk("clamp_idx", 32'(bus.line_idx), 0);

        // mid-line config change, then enable drop at line_idx 1
        bus.cfg_f1_cnt = 10'd20;
        bus.cfg_period = 24'd3000;
        bus.cfg_lines  = 16'd4;
        done_dly = 1000;
        do_reset();
        e = cyc;
        bus.enable = 1'b1;
        s1 = e + 2;
        s2 = s1 + 3001;
        push_ls(s1, 20, 0, 1);
        push_ls(s2, 40, 1, 0);
        goto(s1 + 500);
        bus.cfg_f1_cnt = 10'd40;
        @(negedge sys_clk);
        chk("cfg_f1_midline", 32'(bus.f1_cnt), 20);
        goto(s1 + 3000);
        @(negedge sys_clk);
        chk("cfg_f1_latch_cycle", 32'(bus.f1_cnt), 20);
        goto(s2 + 1);
        @(negedge sys_clk);
        chk("cfg_f1_next_line", 32'(bus.f1_cnt), 40);
        goto(s2 + 100);
        bus.enable = 1'b0;
        goto(s2 + 3010);
        @(negedge sys_clk);
        chk("dis_busy", 32'(bus.busy), 0);
        chk("dis_idx_kept", 32'(bus.line_idx), 2);
        s3 = s2 + 3012;
        push_ls(s3, 40, 2, 0);
        bus.enable = 1'b1;
        goto(s3 + 10);
        @(negedge sys_clk);
        chk("reen_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        bus.enable = 1'b0;
        goto(cyc + 1);
        @(negedge sys_clk);
        chk("reen_rst_idx", 32'(bus.line_idx), 0);
        rst = 1'b0;

        // trigger mode
        bus.cfg_mode   = 1'b1;
        bus.cfg_f1_cnt = 10'd30;
        bus.cfg_period = 24'd2000;
        bus.cfg_lines  = 16'd2;
        done_dly = 100;
        do_reset();
        e = cyc;
        bus.enable = 1'b1;
        t = e + 10;
        push_ls(t + LAT, 30, 0, 1);
        goto(t);
        bus.ext_trig = 1'b1;
        goto(t + 3);
        bus.ext_trig = 1'b0;
        goto(t + 5);
        @(negedge sys_clk);
        chk("trig_no_overrun", 32'(bus.trig_overrun), 0);
        goto(t + 20);
        bus.ext_trig = 1'b1;
        goto(t + 23);
        bus.ext_trig = 1'b0;
        goto(t + 30);
        @(negedge sys_clk);
        chk("trig_overrun_set", 32'(bus.trig_overrun), 1);
        goto(t + 40);
        bus.clr_overrun = 1'b1;
        goto(t + 41);
        bus.clr_overrun = 1'b0;
        @(negedge sys_clk);
        chk("trig_overrun_clr", 32'(bus.trig_overrun), 0);
        t2 = t + LAT + 2100;
        push_ls(t2 + LAT, 30, 1, 0);
        fe_q.push_back(t2 + LAT + 100);
        goto(t2);
        bus.ext_trig = 1'b1;
        goto(t2 + 3);
        bus.ext_trig = 1'b0;
        goto(t2 + LAT + 50);
        @(negedge sys_clk);
        chk("trig2_overrun", 32'(bus.trig_overrun), 0);
        chk("trig2_busy", 32'(bus.busy), 1);
        goto(t2 + LAT + 200);
        bus.enable = 1'b0;
        goto(t2 + LAT + 2100);
        @(negedge sys_clk);
        chk("trig_end_busy", 32'(bus.busy), 0);
        chk("trig_end_idx", 32'(bus.line_idx), 0);

        chk("pending_line_starts", 32'(ls_q.size()), 0);
        chk("pending_frame_ends", 32'(fe_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
